// File: rtl/timer_pkg.sv
// Shared definitions for the timer controller: register map, bit positions, FSM encoding.
// Prescaler-related items are only used when TIMER_PRESCALER_EN is defined.
package timer_pkg;

  localparam logic [4:0] AddrCtrl   = 5'h00;
  localparam logic [4:0] AddrLimit  = 5'h04;
  localparam logic [4:0] AddrCount  = 5'h08;
  localparam logic [4:0] AddrStatus = 5'h0C;
  localparam logic [4:0] AddrPresc  = 5'h10;

  localparam int unsigned CtrlEnBit    = 0;
  localparam int unsigned CtrlModeBit  = 1;
  localparam int unsigned CtrlIeBit    = 2;
  localparam int unsigned StatusExpBit = 0;
  localparam int unsigned StatusRunBit = 1;

  localparam int unsigned PrescWidth = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Registers are word aligned; the two low address bits never select anything.
  function automatic logic [4:0] word_addr(input logic [4:0] a);
    return {a[4:2], 2'b00};
  endfunction

endpackage

// File: rtl/timer_counter.sv
// 32-bit limit counter: counts on tick while enabled, flags expiry at COUNT >= LIMIT,
// then either wraps to 0 (wrap_i) or holds.
module timer_counter (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic        tick_i,
  input  logic        wrap_i,
  input  logic [31:0] limit_i,
  output logic [31:0] count_o,
  output logic        expire_o
);

  logic [31:0] count_q, count_d;
  logic        at_limit;

  // >= rather than == so a limit lowered below the count expires instead of wrapping 2^32.
  assign at_limit = (count_q >= limit_i);
  assign expire_o = en_i & tick_i & at_limit;
  assign count_o  = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && tick_i) begin
      if (!at_limit) begin
        count_d = count_q + 32'd1;
      end else if (wrap_i) begin
        count_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Memory-mapped timer controller: bus decode, CTRL/LIMIT/STATUS registers and IDLE/RUN/DONE FSM.
// Define TIMER_PRESCALER_EN to add the PRESC register at 0x10 and a prescaled tick.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter logic [31:0] RESET_LIMIT = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        running
);

  state_e      state_q, state_d;
  logic        en_q, en_d, mode_q, mode_d, ie_q, ie_d;
  logic        exp_q, exp_d, irq_q, irq_d, running_q, running_d;
  logic [31:0] limit_q, limit_d;
  logic [31:0] count;
  logic        expire, tick, clr;
  logic [4:0]  waddr;
  logic        ctrl_wr, limit_wr, status_wr;
  logic        unused_addr_lsbs;

  assign waddr            = word_addr(addr);
  assign ctrl_wr          = we && (waddr == AddrCtrl);
  assign limit_wr         = we && (waddr == AddrLimit);
  assign status_wr        = we && (waddr == AddrStatus);
  assign unused_addr_lsbs = ^addr[1:0];

`ifdef TIMER_PRESCALER_EN
  logic [PrescWidth-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
  logic                  presc_wr;

  assign presc_wr = we && (waddr == AddrPresc);
  assign tick     = (state_q == StRun) && (pcnt_q == presc_q);

  always_comb begin
    presc_d = presc_wr ? wdata[PrescWidth-1:0] : presc_q;
    // Any CTRL write is a start, restart or stop, so the prescale phase restarts too.
    if (ctrl_wr || (state_q != StRun) || tick) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  timer_counter u_counter (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clr_i    (clr),
    .en_i     (state_q == StRun),
    .tick_i   (tick),
    .wrap_i   (mode_q),
    .limit_i  (limit_q),
    .count_o  (count),
    .expire_o (expire)
  );

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    mode_d  = mode_q;
    ie_d    = ie_q;
    limit_d = limit_wr ? wdata : limit_q;
    clr     = 1'b0;
    // A CTRL write overrides the FSM reaction to a simultaneous expiry.
    if (ctrl_wr) begin
      en_d    = wdata[CtrlEnBit];
      mode_d  = wdata[CtrlModeBit];
      ie_d    = wdata[CtrlIeBit];
      clr     = 1'b1;
      state_d = wdata[CtrlEnBit] ? StRun : StIdle;
    end else if (expire && !mode_q) begin
      state_d = StDone;
      en_d    = 1'b0;
    end
    exp_d = exp_q;
    if (status_wr && wdata[StatusExpBit]) begin
      exp_d = 1'b0;
    end
    if (expire) begin
      exp_d = 1'b1;
    end
    irq_d     = exp_q & ie_q;
    running_d = (state_d == StRun);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      en_q      <= 1'b0;
      mode_q    <= 1'b0;
      ie_q      <= 1'b0;
      limit_q   <= RESET_LIMIT;
      exp_q     <= 1'b0;
      irq_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      ie_q      <= ie_d;
      limit_q   <= limit_d;
      exp_q     <= exp_d;
      irq_q     <= irq_d;
      running_q <= running_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (waddr)
      AddrCtrl: begin
        rdata[CtrlEnBit]   = en_q;
        rdata[CtrlModeBit] = mode_q;
        rdata[CtrlIeBit]   = ie_q;
      end
      AddrLimit: rdata = limit_q;
      AddrCount: rdata = count;
      AddrStatus: begin
        rdata[StatusExpBit] = exp_q;
        rdata[StatusRunBit] = running_q;
      end
`ifdef TIMER_PRESCALER_EN
      AddrPresc: rdata[PrescWidth-1:0] = presc_q;
`endif
      default: rdata = '0;
    endcase
  end

  assign irq     = irq_q;
  assign running = running_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl; inputs change and outputs are sampled
// in the clock low phase, away from the rising edge.
module tb_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  logic        running;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] ACtrl   = 5'h00;
  localparam logic [4:0] ALimit  = 5'h04;
  localparam logic [4:0] ACount  = 5'h08;
  localparam logic [4:0] AStatus = 5'h0C;
  localparam logic [4:0] APresc  = 5'h10;

  timer_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq     (irq),
    .running (running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  // Called in the low phase; the write lands on the next rising edge.
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    we    = 1'b1;
    addr  = a;
    wdata = d;
    @(negedge clk);
    we    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_running", {31'b0, running}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    rd(ACtrl, 32'h0, "rst_ctrl");
    rd(ALimit, 32'hFFFF_FFFF, "rst_limit");
    rd(AStatus, 32'h0, "rst_status");
    bus_write(ACount, 32'd123);
    rd(ACount, 32'h0, "count_ro");
    rd(APresc, 32'h0, "presc_rst_or_unmapped");
    rd(5'h14, 32'h0, "unmapped");

    // Periodic, LIMIT = 4, IE = 1
    bus_write(ALimit, 32'd4);
    bus_write(ACtrl, 32'h7);
    rd(ACount, 32'd0, "per_start");
    check("per_running", {31'b0, running}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      rd(ACount, i, "per_seq");
    end
    rd(AStatus, 32'h2, "per_noexp");
    @(negedge clk);
    rd(ACount, 32'd0, "per_wrap");
    rd(AStatus, 32'h3, "per_exp");
    check("per_irq_lag", {31'b0, irq}, 32'd0);
    @(negedge clk);
    rd(ACount, 32'd1, "per_after");
    check("per_irq", {31'b0, irq}, 32'd1);
    bus_write(AStatus, 32'h1);
    rd(AStatus, 32'h2, "w1c_clear");
    check("w1c_irq_lag", {31'b0, irq}, 32'd1);
    @(negedge clk);
    rd(ACount, 32'd3, "w1c_count");
    check("w1c_irq_drop", {31'b0, irq}, 32'd0);
    repeat (2) @(negedge clk);
    rd(AStatus, 32'h3, "per_exp2");

    // W1C collides with expiry: set wins
    repeat (4) @(negedge clk);
    rd(ACount, 32'd4, "coll_pre");
    bus_write(AStatus, 32'h1);
    rd(ACount, 32'd0, "coll_wrap");
    rd(AStatus, 32'h3, "coll_exp");

    // LIMIT shrink below COUNT
    bus_write(AStatus, 32'h1);
    bus_write(ALimit, 32'd100);
    rd(AStatus, 32'h2, "shr_clr");
    bus_write(ACtrl, 32'h3);
    rd(ACount, 32'd0, "shr_restart");
    repeat (10) @(negedge clk);
    rd(ACount, 32'd10, "shr_ten");
    bus_write(ALimit, 32'd5);
    rd(ACount, 32'd11, "shr_eleven");
    @(negedge clk);
    rd(ACount, 32'd0, "shr_wrap");
    rd(AStatus, 32'h3, "shr_exp");
    @(negedge clk);
    check("ie_off_irq", {31'b0, irq}, 32'd0);

    // Stop
    bus_write(ACtrl, 32'h0);
    rd(ACount, 32'd0, "stop_count");
    rd(AStatus, 32'h1, "stop_status");
    check("stop_running", {31'b0, running}, 32'd0);

    // One-shot, LIMIT = 3
    bus_write(AStatus, 32'h1);
    bus_write(ALimit, 32'd3);
    bus_write(ACtrl, 32'h1);
    rd(ACount, 32'd0, "os_start");
    repeat (3) @(negedge clk);
    rd(ACount, 32'd3, "os_three");
    rd(AStatus, 32'h2, "os_noexp");
    @(negedge clk);
    rd(ACount, 32'd3, "os_hold");
    rd(ACtrl, 32'h0, "os_ctrl_clr");
    rd(AStatus, 32'h1, "os_exp");
    check("os_running", {31'b0, running}, 32'd0);
    @(negedge clk);
    rd(ACount, 32'd3, "os_hold2");
    bus_write(ACtrl, 32'h1);
    rd(ACount, 32'd0, "os_restart");
    check("os_rerun", {31'b0, running}, 32'd1);
    @(negedge clk);
    rd(ACount, 32'd1, "os_recount");

    // LIMIT = 0 periodic
    bus_write(ACtrl, 32'h0);
    bus_write(ALimit, 32'd0);
    bus_write(AStatus, 32'h1);
    bus_write(ACtrl, 32'h3);
    rd(AStatus, 32'h2, "l0_start");
    @(negedge clk);
    rd(ACount, 32'd0, "l0_count");
    rd(AStatus, 32'h3, "l0_exp");

    // Asynchronous reset mid-count
    bus_write(ALimit, 32'd20);
    bus_write(ACtrl, 32'h7);
    repeat (7) @(negedge clk);
    rd(ACount, 32'd7, "ar_seven");
    check("ar_irq_pre", {31'b0, irq}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("ar_irq", {31'b0, irq}, 32'd0);
    check("ar_running", {31'b0, running}, 32'd0);
    rd(ACount, 32'd0, "ar_count");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(ALimit, 32'hFFFF_FFFF, "ar_limit");

`ifdef TIMER_PRESCALER_EN
    bus_write(APresc, 32'd2);
    bus_write(ALimit, 32'd1);
    bus_write(ACtrl, 32'h3);
    rd(APresc, 32'd2, "ps_reg");
    repeat (5) @(negedge clk);
    rd(ACount, 32'd1, "ps_count");
    rd(AStatus, 32'h2, "ps_noexp");
    @(negedge clk);
    rd(ACount, 32'd0, "ps_wrap");
    rd(AStatus, 32'h3, "ps_exp");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
